// File: rtl/logic_gates_pkg.sv
// Shared definitions for the two-input gate checkers: FSM states and
// mismatch-mask bit positions.
package logic_gates_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MSK_AND = 0;
  localparam int MSK_OR  = 1;
  localparam int MSK_NOT = 2;

endpackage

// File: rtl/logic_gates_2_ref_model.sv
// Golden reference for the two-input gate block: expected AND, OR and
// NOT(A) for a given operand pair. Purely combinational.
module logic_gates_2_ref_model (
  input  logic a,
  input  logic b,
  output logic exp_and,
  output logic exp_or,
  output logic exp_not
);

  // Reference truth functions.
  always_comb begin
    exp_and = a & b;
    exp_or  = a | b;
    exp_not = ~a;
  end

endmodule

// File: rtl/logic_gates_2_checker.sv
// Response checker for the two-input gate block. Accepts up to NUM_VECTORS
// samples per run, compares each one a cycle later against the reference
// model, counts vectors and failures, latches the first failure and
// reports pass/fail once the run completes.
//
//   state | meaning
//   IDLE  | waiting for iStart after reset
//   RUN   | accepting and comparing vectors
//   DONE  | run complete, results held until the next iStart
module logic_gates_2_checker
  import logic_gates_pkg::*;
#(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic             iValid,
  input  logic             iA,
  input  logic             iB,
  input  logic             iAnd,
  input  logic             iOr,
  input  logic             iNot,
  output logic             oBusy,
  output logic             oDone,
  output logic             oPass,
  output logic [CNT_W-1:0] oVecCnt,
  output logic [CNT_W-1:0] oErrCnt,
  output logic [CNT_W-1:0] oFirstErrIdx,
  output logic [2:0]       oFirstErrMask
);

  localparam logic [CNT_W-1:0] NUM_V    = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t           state;
  state_t           state_nxt;
  logic             restart;
  logic             accept;
  logic             cmp_last;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] first_idx;
  logic [2:0]       first_mask;
  logic             first_seen;
  logic [2:0]       mask;
  logic             s1_valid;
  logic             s1_a;
  logic             s1_b;
  logic             s1_and;
  logic             s1_or;
  logic             s1_not;
  logic             ref_and;
  logic             ref_or;
  logic             ref_not;

  // iStart only counts outside RUN; in RUN it is ignored.
  assign restart  = iStart && (state != RUN);
  assign accept   = (state == RUN) && iValid && (acc_cnt < NUM_V);
  assign cmp_last = s1_valid && (vec_cnt == LAST_IDX);

  logic_gates_2_ref_model u_ref (
    .a       (s1_a),
    .b       (s1_b),
    .exp_and (ref_and),
    .exp_or  (ref_or),
    .exp_not (ref_not)
  );

  // Per-gate mismatch of the registered sample against the reference.
  always_comb begin
    mask          = 3'b000;
    mask[MSK_AND] = s1_and ^ ref_and;
    mask[MSK_OR]  = s1_or ^ ref_or;
    mask[MSK_NOT] = s1_not ^ ref_not;
  end

  // Next-state logic: leave RUN on the edge that compares the last vector.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iStart) state_nxt = RUN;
      RUN:     if (cmp_last) state_nxt = DONE;
      DONE:    if (iStart) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iClk) begin
    if (!iRst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Stage 1: capture accepted samples and count accepts.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      s1_valid <= 1'b0;
      acc_cnt  <= '0;
      s1_a     <= 1'b0;
      s1_b     <= 1'b0;
      s1_and   <= 1'b0;
      s1_or    <= 1'b0;
      s1_not   <= 1'b0;
    end else if (restart) begin
      s1_valid <= 1'b0;
      acc_cnt  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        acc_cnt <= acc_cnt + 1'b1;
        s1_a    <= iA;
        s1_b    <= iB;
        s1_and  <= iAnd;
        s1_or   <= iOr;
        s1_not  <= iNot;
      end
    end
  end

  // Stage 2: compare, count, and latch the first failing vector of the run.
  always_ff @(posedge iClk) begin
    if (!iRst_n || restart) begin
      vec_cnt    <= '0;
      err_cnt    <= '0;
      first_idx  <= '0;
      first_mask <= 3'b000;
      first_seen <= 1'b0;
    end else if (s1_valid) begin
      vec_cnt <= vec_cnt + 1'b1;
      if (mask != 3'b000) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (!first_seen) begin
          first_seen <= 1'b1;
          first_idx  <= vec_cnt;
          first_mask <= mask;
        end
      end
    end
  end

  assign oBusy         = (state == RUN);
  assign oDone         = (state == DONE);
  assign oPass         = (state == DONE) && (err_cnt == '0);
  assign oVecCnt       = vec_cnt;
  assign oErrCnt       = err_cnt;
  assign oFirstErrIdx  = first_idx;
  assign oFirstErrMask = first_mask;

endmodule

// File: tb/tb_logic_gates_2_checker.sv
// Scoreboard bench for logic_gates_2_checker: a default instance (4 vectors,
// 8-bit counters) and a small instance (3 vectors, 2-bit counters).
module tb_logic_gates_2_checker;

  typedef struct {
    int vec;
    int err;
    int idx;
    int mask;
    int pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start [2];
  logic valid [2];
  logic a [2];
  logic b [2];
  logic g_and [2];
  logic g_or [2];
  logic g_not [2];

  logic       m_busy, m_done, m_pass;
  logic [7:0] m_vec, m_err, m_idx;
  logic [2:0] m_mask;
  logic       s_busy, s_done, s_pass;
  logic [1:0] s_vec, s_err, s_idx;
  logic [2:0] s_mask;

  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   dp [2];

  logic_gates_2_checker dut_m (
    .iClk(clk), .iRst_n(rst_n), .iStart(start[0]), .iValid(valid[0]),
    .iA(a[0]), .iB(b[0]), .iAnd(g_and[0]), .iOr(g_or[0]), .iNot(g_not[0]),
    .oBusy(m_busy), .oDone(m_done), .oPass(m_pass), .oVecCnt(m_vec),
    .oErrCnt(m_err), .oFirstErrIdx(m_idx), .oFirstErrMask(m_mask)
  );

  logic_gates_2_checker #(.NUM_VECTORS(3), .CNT_W(2)) dut_s (
    .iClk(clk), .iRst_n(rst_n), .iStart(start[1]), .iValid(valid[1]),
    .iA(a[1]), .iB(b[1]), .iAnd(g_and[1]), .iOr(g_or[1]), .iNot(g_not[1]),
    .oBusy(s_busy), .oDone(s_done), .oPass(s_pass), .oVecCnt(s_vec),
    .oErrCnt(s_err), .oFirstErrIdx(s_idx), .oFirstErrMask(s_mask)
  );

  function automatic int get_busy(input int s); return s == 0 ? int'(m_busy) : int'(s_busy); endfunction
  function automatic int get_done(input int s); return s == 0 ? int'(m_done) : int'(s_done); endfunction
  function automatic int get_pass(input int s); return s == 0 ? int'(m_pass) : int'(s_pass); endfunction
  function automatic int get_vec(input int s);  return s == 0 ? int'(m_vec)  : int'(s_vec);  endfunction
  function automatic int get_err(input int s);  return s == 0 ? int'(m_err)  : int'(s_err);  endfunction
  function automatic int get_idx(input int s);  return s == 0 ? int'(m_idx)  : int'(s_idx);  endfunction
  function automatic int get_mask(input int s); return s == 0 ? int'(m_mask) : int'(s_mask); endfunction

  task automatic chk(input string name, input int s, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s dut=%0d actual=%0d required=%0d t=%0t", name, s, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data(input int s);
    a[s]     = 1'($urandom);
    b[s]     = 1'($urandom);
    g_and[s] = 1'($urandom);
    g_or[s]  = 1'($urandom);
    g_not[s] = 1'($urandom);
  endtask

  // Monitor: whenever a DUT enters DONE, pop its expected run result.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (get_done(s) != 0 && !dp[s]) begin
        exp_t e;
        if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL unexpected_done dut=%0d actual=done required=no_pending_run", s);
        end else begin
          if (s == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("vec_cnt", s, get_vec(s), e.vec);
          chk("err_cnt", s, get_err(s), e.err);
          chk("first_idx", s, get_idx(s), e.idx);
          chk("first_mask", s, get_mask(s), e.mask);
          chk("pass", s, get_pass(s), e.pass);
        end
      end
      dp[s] = (get_done(s) != 0);
    end
  end

  // One full run: vector pairs packed in ab ({A,B} per vector), gate-output
  // corruption in cor (3 bits per vector: bit0 And, bit1 Or, bit2 Not).
  task automatic run(input int s, input logic [7:0] ab, input logic [11:0] cor,
                     input int gap, input bit noise);
    int         nv, cmax, errs, first_i, first_m, g;
    bit         found;
    logic [3:0] tt_and, tt_or, tt_not;
    logic [1:0] idx;
    logic [2:0] c, m;
    logic       o_and, o_or, o_not;
    exp_t       e;
    nv = (s == 0) ? 4 : 3;
    cmax = (s == 0) ? 255 : 3;
    tt_and = 4'b1000;
    tt_or  = 4'b1110;
    tt_not = 4'b0011;
    errs = 0; first_i = 0; first_m = 0; found = 0;
    for (int i = 0; i < nv; i++) begin
      idx = {ab[2*i+1], ab[2*i]};
      c = cor[3*i +: 3];
      o_and = tt_and[idx] ^ c[0];
      o_or  = tt_or[idx] ^ c[1];
      o_not = tt_not[idx] ^ c[2];
      m = {o_not != tt_not[idx], o_or != tt_or[idx], o_and != tt_and[idx]};
      if (m != 3'b000) begin
        errs++;
        if (!found) begin
          found = 1;
          first_i = i;
          first_m = int'(m);
        end
      end
    end
    e.vec = nv;
    e.err = (errs > cmax) ? cmax : errs;
    e.idx = first_i;
    e.mask = first_m;
    e.pass = (errs == 0) ? 1 : 0;
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);

    if (noise) begin
      repeat (2) begin
        valid[s] = 1'b1;
        rand_data(s);
        step();
      end
    end
    valid[s] = 1'b0;
    start[s] = 1'b1;
    step();
    start[s] = 1'b0;
    for (int i = 0; i < nv; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        valid[s] = 1'b0;
        start[s] = noise ? 1'($urandom) : 1'b0;
        rand_data(s);
        step();
      end
      idx = {ab[2*i+1], ab[2*i]};
      c = cor[3*i +: 3];
      valid[s] = 1'b1;
      start[s] = noise ? 1'($urandom) : 1'b0;
      a[s] = ab[2*i+1];
      b[s] = ab[2*i];
      g_and[s] = tt_and[idx] ^ c[0];
      g_or[s]  = tt_or[idx] ^ c[1];
      g_not[s] = tt_not[idx] ^ c[2];
      step();
    end
    start[s] = 1'b0;
    valid[s] = noise;
    rand_data(s);
    chk("done_early", s, get_done(s), 0);
    step();
    valid[s] = 1'b0;
    chk("done_latency", s, get_done(s), 1);
    chk("busy_in_done", s, get_busy(s), 0);
    @(negedge clk);
    repeat (2) begin
      valid[s] = 1'b1;
      rand_data(s);
      step();
    end
    valid[s] = 1'b0;
    chk("hold_vec", s, get_vec(s), nv);
    chk("hold_done", s, get_done(s), 1);
  endtask

  task automatic check_cleared(input int s, input string tag);
    chk({tag, "_busy"}, s, get_busy(s), 0);
    chk({tag, "_done"}, s, get_done(s), 0);
    chk({tag, "_pass"}, s, get_pass(s), 0);
    chk({tag, "_vec"}, s, get_vec(s), 0);
    chk({tag, "_err"}, s, get_err(s), 0);
    chk({tag, "_idx"}, s, get_idx(s), 0);
    chk({tag, "_mask"}, s, get_mask(s), 0);
  endtask

  function automatic logic [11:0] rand_cor();
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 2) == 0) r[3*i +: 3] = 3'($urandom_range(1, 7));
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      start[s] = 0; valid[s] = 0; a[s] = 0; b[s] = 0;
      g_and[s] = 0; g_or[s] = 0; g_not[s] = 0;
    end
    repeat (2) step();
    for (int s = 0; s < 2; s++) check_cleared(s, "reset");
    rst_n = 1'b1;
    step();

    // Vectors (A,B) = 00,10,01,11 packed as {A,B} per vector, vector 0 in LSBs.
    run(0, 8'b11_01_10_00, 12'b000_000_000_000, 0, 0);
    run(0, 8'b11_01_10_00, 12'b000_001_000_000, 0, 0);
    run(0, 8'b11_01_10_00, 12'b010_000_100_000, 0, 0);
    run(0, 8'b11_01_10_00, 12'b000_000_000_000, 2, 1);
    for (int r = 0; r < 6; r++)
      run(0, 8'($urandom), rand_cor(), -1, 1);

    // Small instance: every vector wrong, then restart with iValid in DONE.
    run(1, 8'($urandom), 12'b000_111_010_100, 0, 0);
    start[1] = 1'b1;
    valid[1] = 1'b1;
    rand_data(1);
    step();
    start[1] = 1'b0;
    valid[1] = 1'b0;
    chk("restart_busy", 1, get_busy(1), 1);
    chk("restart_vec", 1, get_vec(1), 0);
    chk("restart_err", 1, get_err(1), 0);
    chk("restart_done", 1, get_done(1), 0);
    repeat (3) step();
    chk("restart_no_accept", 1, get_vec(1), 0);
    run(1, 8'($urandom), 12'b000_000_000_000, 0, 0);
    run(1, 8'($urandom), rand_cor(), -1, 1);

    // Reset in the middle of a run aborts it.
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (2) begin
      valid[0] = 1'b1;
      rand_data(0);
      step();
    end
    valid[0] = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) check_cleared(s, "abort");
    step();
    chk("abort_stay_idle", 0, get_busy(0), 0);
    run(0, 8'($urandom), rand_cor(), -1, 1);

    repeat (3) step();
    chk("scoreboard_empty", 0, q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
